// File: rtl/mem_load_port_pkg.sv
// Shared handshake constants for the load port and its data FIFO.
//
// Width helpers:
//   cnt_width(depth) : bits for a counter that holds 0..depth
//   ptr_width(depth) : bits for an index into a depth-entry array
//
// Optional feature macro used by this slice: MEM_LOAD_PORT_BYPASS_EN
package mem_load_port_pkg;

  // Counts run 0..depth inclusive, so they need one state more than an index.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Index width for a depth-entry array; a single entry still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_load_port_data_fifo.sv
// load_data_fifo: in-order data FIFO for load responses.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   i_wr_en       : write request (ignored while full)
//   i_wr_data     : write data
//   i_rd_en       : pop request (ignored while empty)
//   o_rd_data     : head entry, zero while empty
//   o_empty       : no entries stored
//   o_full        : FIFO_DEPTH entries stored
//
// Data written in cycle N is visible at the head in cycle N+1.
module load_data_fifo
  import mem_load_port_pkg::*;
#(
  parameter int DATA_TYPE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [DATA_TYPE-1:0] i_wr_data,
  input  logic                 i_rd_en,
  output logic [DATA_TYPE-1:0] o_rd_data,
  output logic                 o_empty,
  output logic                 o_full
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_TYPE-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic w_wr;
  logic w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == DEPTH_CNT);
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  // Masking the head keeps dataOut at zero whenever nothing is stored,
  // including right after reset when the array holds stale contents.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap at FIFO_DEPTH rather than at a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_load_port.sv
// mem_load_port: connects a dataflow load to one ldAddr/ldData lane pair of
// a memory controller.
//
// Ports:
//   clk, rst                                   : clock, synchronous active-high reset
//   addrIn / addrIn_valid / addrIn_ready       : load address from the circuit
//   dataOut / dataOut_valid / dataOut_ready    : load result to the circuit
//   addrToMem / addrToMem_valid / addrToMem_ready : address to the controller
//   dataFromMem / dataFromMem_valid / dataFromMem_ready : data from the controller
//
// Optional feature: define MEM_LOAD_PORT_BYPASS_EN to forward dataFromMem
// straight to dataOut when the FIFO is empty and dataOut_ready is high.
// Without it every response passes through the FIFO (one cycle latency).
module mem_load_port
  import mem_load_port_pkg::*;
#(
  parameter int DATA_TYPE  = 32,
  parameter int ADDR_TYPE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_TYPE-1:0] addrIn,
  input  logic                 addrIn_valid,
  output logic                 addrIn_ready,
  output logic [DATA_TYPE-1:0] dataOut,
  output logic                 dataOut_valid,
  input  logic                 dataOut_ready,
  output logic [ADDR_TYPE-1:0] addrToMem,
  output logic                 addrToMem_valid,
  input  logic                 addrToMem_ready,
  input  logic [DATA_TYPE-1:0] dataFromMem,
  input  logic                 dataFromMem_valid,
  output logic                 dataFromMem_ready
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic                 r_slot_valid;
  logic [ADDR_TYPE-1:0] r_slot_addr;
  logic [CNT_W-1:0]     r_outstanding;

  logic                 w_addr_in_fire;
  logic                 w_addr_out_fire;
  logic                 w_data_out_fire;
  logic                 w_mem_fire;
  logic                 w_fifo_wr;
  logic                 w_fifo_rd;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [DATA_TYPE-1:0] w_fifo_head;

  assign dataFromMem_ready = ~w_fifo_full;
  assign w_mem_fire        = dataFromMem_valid & ~w_fifo_full;

`ifdef MEM_LOAD_PORT_BYPASS_EN
  logic w_bypass;
  // A response arriving into an empty FIFO goes straight out when the
  // consumer is ready; otherwise it is stored and stays at the head.
  assign w_bypass      = w_fifo_empty & dataOut_ready;
  assign dataOut_valid = ~w_fifo_empty | dataFromMem_valid;
  assign dataOut       = ~w_fifo_empty     ? w_fifo_head :
                         dataFromMem_valid ? dataFromMem : '0;
  assign w_fifo_wr     = w_mem_fire & ~w_bypass;
`else
  assign dataOut_valid = ~w_fifo_empty;
  assign dataOut       = w_fifo_head;
  assign w_fifo_wr     = w_mem_fire;
`endif

  assign w_data_out_fire = dataOut_valid & dataOut_ready;
  assign w_fifo_rd       = w_data_out_fire & ~w_fifo_empty;

  assign addrToMem       = r_slot_addr;
  assign addrToMem_valid = r_slot_valid;
  assign w_addr_out_fire = r_slot_valid & addrToMem_ready;

  // Credit rule: an address is only accepted when its response is
  // guaranteed a FIFO entry, so the FIFO never back-pressures memory.
  // A dataOut transfer in the same cycle frees a credit immediately.
  assign addrIn_ready   = ~rst
                        & (~r_slot_valid | addrToMem_ready)
                        & ((r_outstanding < DEPTH_CNT) | w_data_out_fire);
  assign w_addr_in_fire = addrIn_valid & addrIn_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_valid  <= 1'b0;
      r_slot_addr   <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_addr_in_fire) begin
        r_slot_valid <= 1'b1;
        r_slot_addr  <= addrIn;
      end else if (w_addr_out_fire) begin
        r_slot_valid <= 1'b0;
      end
      case ({w_addr_in_fire, w_data_out_fire})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  load_data_fifo #(
    .DATA_TYPE  (DATA_TYPE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_load_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (dataFromMem),
    .i_rd_en   (w_fifo_rd),
    .o_rd_data (w_fifo_head),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

endmodule

// File: doc/mem_load_port.md
MEM_LOAD_PORT -- requirements
Module: mem_load_port

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 32: load data width.
REQ-002 SHALL have parameter ADDR_TYPE, default 32: load address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: max outstanding loads and data FIFO entries; legal range 1..16.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising edge), then rst input 1 (synchronous, active-high).
REQ-005 SHALL have addrIn input ADDR_TYPE, with addrIn_valid input 1 and addrIn_ready output 1: load address channel from the dataflow circuit.
REQ-006 SHALL have dataOut output DATA_TYPE, with dataOut_valid output 1 and dataOut_ready input 1: load result channel to the circuit.
REQ-007 SHALL have addrToMem output ADDR_TYPE, with addrToMem_valid output 1 and addrToMem_ready input 1: feeds one ldAddr lane of the memory controller.
REQ-008 SHALL have dataFromMem input DATA_TYPE, with dataFromMem_valid input 1 and dataFromMem_ready output 1: consumes one ldData lane of the memory controller.

Function
REQ-009 SHALL treat a transfer as occurring on any channel in a cycle where valid and ready are both 1 at the rising edge.
REQ-010 SHALL hold the address in a one-entry register slot; addrToMem_valid is 1 iff the slot is full; addrToMem is the slot contents.
REQ-011 SHALL fill the slot on an addrIn transfer, so the address appears on addrToMem the cycle after acceptance (latency 1).
REQ-012 SHALL empty the slot on an addrToMem transfer unless it is refilled in the same cycle.
REQ-013 SHALL keep an outstanding counter (0..FIFO_DEPTH): +1 on an addrIn transfer, -1 on a dataOut transfer, unchanged when both occur.
REQ-014 SHALL drive addrIn_ready = (slot empty OR addrToMem_ready) AND (outstanding < FIFO_DEPTH OR a dataOut transfer occurs this cycle).
REQ-015 SHALL store dataFromMem into a FIFO_DEPTH-entry data FIFO in arrival order; dataFromMem_ready = NOT fifo_full.
REQ-016 SHALL never make fifo_full limit throughput: the credit rule of REQ-014 guarantees space for every issued load.
REQ-017 SHALL drive dataOut_valid = NOT fifo_empty and dataOut = FIFO head; data written in cycle N is visible at the head in cycle N+1.
REQ-018 SHALL accept a FIFO write and read in the same cycle when full or empty, except that an empty FIFO can only be read under REQ-025.
REQ-019 SHALL wrap FIFO pointers modulo FIFO_DEPTH.
REQ-020 SHALL hold addrToMem, addrToMem_valid, dataOut and dataOut_valid stable while the respective ready is 0.
REQ-021 SHALL be free of combinational paths from addrToMem_ready to dataOut_valid or from dataOut_ready to addrToMem_valid.

Reset
REQ-022 SHALL, while rst=1 at a clock edge, clear the address slot, outstanding counter and FIFO pointers; addrToMem_valid=0, dataOut_valid=0, dataOut=0, addrToMem=0.
REQ-023 SHALL discard in-flight loads on reset mid-operation; responses arriving after reset are the memory controller's responsibility (reset jointly).
REQ-024 SHALL drive addrIn_ready=0 while rst=1 and dataFromMem_ready=1 from the first cycle after reset.

Configuration
REQ-025 SHALL, when MEM_LOAD_PORT_BYPASS_EN is defined, forward dataFromMem to dataOut combinationally when the FIFO is empty and dataOut_ready=1 (latency 0, no FIFO write); when undefined, all data passes through the FIFO (latency 1).

Structure
REQ-026 SHALL place pointer and counter width derivation ($clog2(FIFO_DEPTH+1)) in the shared handshake constants package.
REQ-027 SHALL instantiate the data FIFO as a sub-module named load_data_fifo (parameters DATA_TYPE, FIFO_DEPTH).

Verification
REQ-028 SHALL cover single load: addrIn=0x10 accepted at cycle 0 -> addrToMem=0x10 valid at cycle 1; dataFromMem=0xAB at cycle 3 -> dataOut=0xAB valid at cycle 4 (cycle 3 with bypass).
REQ-029 SHALL cover credit stall: FIFO_DEPTH=4, dataOut_ready=0, 4 addresses issued -> addrIn_ready=0 on the 5th attempt; one dataOut transfer -> addrIn_ready=1 in the same cycle.
REQ-030 SHALL cover in-order back-pressure: responses 1,2,3,4 with dataOut_ready toggling 1010... -> dataOut emits 1,2,3,4 in order, each value stable while stalled.
REQ-031 SHALL cover simultaneous events: addrIn transfer and dataOut transfer in one cycle at outstanding=2 -> outstanding stays 2.
REQ-032 SHALL cover reset mid-operation: rst asserted with outstanding=3 and FIFO holding 2 entries -> next cycle all valids 0, outstanding 0, addrIn_ready=1 after rst is released.
REQ-033 SHALL cover wrap-around: 10 back-to-back loads with FIFO_DEPTH=4 and continuous ready -> data 0..9 returned in order, throughput 1 per cycle.
